// File: rtl/dadda_unsigned_divider_seq_if.sv
// Handshake bundle for the sequential unsigned divider: operand input
// channel (valid/ready) and result output channel (valid/ready).
interface dadda_unsigned_divider_seq_if #(
  parameter int unsigned WIDTH = 4
);

  logic                 in_valid;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 overflow;
  logic                 div_by_zero;

  // Side that issues operands and consumes results
  modport master (
    output in_valid,
    output dividend,
    output divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  overflow,
    input  div_by_zero
  );

  // Divider side
  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output overflow,
    output div_by_zero
  );

endinterface

// File: rtl/dadda_unsigned_divider_seq.sv
// Iterative unsigned restoring divider: 2*WIDTH-bit dividend by WIDTH-bit
// divisor, one quotient bit per clock, valid/ready on input and output.
// Overflow (quotient wider than WIDTH, including divide by zero) is detected
// at accept and reported with all-ones quotient and the dividend low half as
// remainder.
module dadda_unsigned_divider_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  dadda_unsigned_divider_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             in_ready_r;
  logic             out_valid_r;

  // Working registers. The partial remainder is kept WIDTH bits wide: it is
  // always below the divisor between steps, so only the shifted value needs
  // the extra bit.
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] div_r;
  logic [CW-1:0]    step;
  logic             ovf_pend;
  logic             dz_pend;

  // Result registers, held until the next completed operation or reset
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             overflow_r;
  logic             div_by_zero_r;

  // Accept-time decode of the operands
  logic             accept;
  logic [WIDTH-1:0] in_hi;
  logic [WIDTH-1:0] in_lo;
  logic             in_dz;
  logic             in_ovf;

  // One restoring step
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             last_step;

  // Operand decode and overflow detection, qualified by the accept handshake
  always_comb begin
    accept = bus.in_valid && in_ready_r;
    in_hi  = bus.dividend[2*WIDTH-1:WIDTH];
    in_lo  = bus.dividend[WIDTH-1:0];
    in_dz  = (bus.divisor == '0);
    in_ovf = in_dz || (in_hi >= bus.divisor);
  end

  // Shift {R,Q} left, trial-subtract divisor, set quotient LSB on success
  always_comb begin
    shifted   = {rem_r, quo_r[WIDTH-1]};
    ge        = (shifted >= {1'b0, div_r});
    rem_next  = ge ? WIDTH'(shifted - {1'b0, div_r}) : shifted[WIDTH-1:0];
    quo_next  = {quo_r[WIDTH-2:0], ge};
    last_step = (step == CW'(WIDTH - 1));
  end

  // Control FSM with registered handshake flags and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      rem_r         <= '0;
      quo_r         <= '0;
      div_r         <= '0;
      step          <= '0;
      ovf_pend      <= 1'b0;
      dz_pend       <= 1'b0;
      quotient_r    <= '0;
      remainder_r   <= '0;
      overflow_r    <= 1'b0;
      div_by_zero_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= BUSY;
            in_ready_r <= 1'b0;
            div_r      <= bus.divisor;
            step       <= '0;
            ovf_pend   <= in_ovf;
            dz_pend    <= in_dz;
            if (in_ovf) begin
              rem_r <= in_lo;
              quo_r <= '1;
            end else begin
              rem_r <= in_hi;
              quo_r <= in_lo;
            end
          end
        end

        // Overflow results pass through BUSY for one cycle so they appear
        // one edge after accept, giving the three-cycle issue interval.
        BUSY: begin
          if (ovf_pend) begin
            state         <= DONE;
            out_valid_r   <= 1'b1;
            quotient_r    <= quo_r;
            remainder_r   <= rem_r;
            overflow_r    <= 1'b1;
            div_by_zero_r <= dz_pend;
          end else begin
            rem_r <= rem_next;
            quo_r <= quo_next;
            step  <= step + CW'(1);
            if (last_step) begin
              state         <= DONE;
              out_valid_r   <= 1'b1;
              quotient_r    <= quo_next;
              remainder_r   <= rem_next;
              overflow_r    <= 1'b0;
              div_by_zero_r <= 1'b0;
            end
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.overflow    = overflow_r;
  assign bus.div_by_zero = div_by_zero_r;

endmodule
